// File: rtl/bank_loader_if.sv
// ============================================================================
// Module      : bank_loader_if
// Description : Stream-in, bank-write and status signals of bank_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bank_loader_if #(
    parameter int IN_W  = 32,
    parameter int LANES = 4
);
    logic                  start;
    logic [6:0]            start_addr;
    logic [IN_W-1:0]       s_data;
    logic                  s_valid;
    logic                  s_last;
    logic                  s_ready;
    logic [IN_W*LANES-1:0] vsi_inputData;
    logic [6:0]            vsi_inputAddr;
    logic                  vsi_inputChipSelect;
    logic                  busy;
    logic                  done;
    logic [7:0]            lines_written;
    logic                  overflow;

    // Stream source / controller side
    modport master (
        output start, start_addr, s_data, s_valid, s_last,
        input  s_ready, vsi_inputData, vsi_inputAddr, vsi_inputChipSelect,
        input  busy, done, lines_written, overflow
    );

    // Loader side
    modport slave (
        input  start, start_addr, s_data, s_valid, s_last,
        output s_ready, vsi_inputData, vsi_inputAddr, vsi_inputChipSelect,
        output busy, done, lines_written, overflow
    );
endinterface

`default_nettype wire

// File: rtl/bank_loader.sv
// ============================================================================
// Module      : bank_loader
// Description : Packs LANES stream words into one bank line per write.
//               Define BANK_LOADER_WRAP_EN to wrap the address past 127.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bank_loader #(
    parameter int IN_W  = 32,
    parameter int LANES = 4
) (
    input  wire logic    vsi_clk,
    input  wire logic    vsi_reset_n,
    bank_loader_if.slave bus
);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int LINE_W = IN_W * LANES;
    localparam int ADDR_W = 7;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [LANE_W-1:0]   r_lane;
    logic [LINE_W-1:0]   r_line_buf;
    logic [LINE_W-1:0]   r_line_out;
    logic                r_line_last;
    logic                r_chip_sel;
    logic                r_ready;
    logic                r_busy;
    logic                r_done;
    logic [7:0]          r_count;
    logic                r_overflow;

    logic [LINE_W-1:0]   w_line_merged;
    logic                w_accept;

    assign w_accept = bus.s_valid && r_ready;

    always_comb begin
        w_line_merged = r_line_buf;
        w_line_merged[r_lane*IN_W +: IN_W] = bus.s_data;
    end

    always_ff @(posedge vsi_clk or negedge vsi_reset_n) begin
        if (!vsi_reset_n) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_lane      <= '0;
            r_line_buf  <= '0;
            r_line_out  <= '0;
            r_line_last <= 1'b0;
            r_chip_sel  <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, HALT: begin
                    if (bus.start) begin
                        r_state    <= FILL;
                        r_addr     <= bus.start_addr;
                        r_lane     <= '0;
                        r_line_buf <= '0;
                        r_count    <= '0;
                        r_ready    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_overflow <= 1'b0;
                    end
                end
                FILL: begin
                    if (w_accept) begin
                        // Final lane or end of stream: hand the line to the bank next cycle
                        if (r_lane == LAST_LANE || bus.s_last) begin
                            r_state     <= WRITE;
                            r_line_out  <= w_line_merged;
                            r_line_buf  <= '0;
                            r_line_last <= bus.s_last;
                            r_chip_sel  <= 1'b1;
                            r_ready     <= 1'b0;
                        end else begin
                            r_line_buf <= w_line_merged;
                            r_lane     <= r_lane + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    r_chip_sel <= 1'b0;
                    r_line_out <= '0;
                    r_lane     <= '0;
                    r_line_buf <= '0;
                    if (r_count != 8'hFF) begin
                        r_count <= r_count + 8'd1;
                    end
                    if (r_line_last) begin
                        r_state <= DONE;
                        r_addr  <= r_addr + 1'b1;
                        r_done  <= 1'b1;
                    end else begin
`ifdef BANK_LOADER_WRAP_EN
                        r_state <= FILL;
                        r_addr  <= r_addr + 1'b1;
                        r_ready <= 1'b1;
`else
                        if (r_addr == '1) begin
                            r_state    <= HALT;
                            r_overflow <= 1'b1;
                        end else begin
                            r_state <= FILL;
                            r_addr  <= r_addr + 1'b1;
                            r_ready <= 1'b1;
                        end
`endif
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready             = r_ready;
    assign bus.vsi_inputData       = r_line_out;
    assign bus.vsi_inputAddr       = r_addr;
    assign bus.vsi_inputChipSelect = r_chip_sel;
    assign bus.busy                = r_busy;
    assign bus.done                = r_done;
    assign bus.lines_written       = r_count;
    assign bus.overflow            = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_bank_loader.sv
// ============================================================================
// Module      : tb_bank_loader
// Description : Directed self-checking bench for bank_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bank_loader;
    logic clk;
    logic rst_n;
    int   cyc;
    int   passed;
    int   total;

    logic [6:0]   wq_addr[$];
    logic [127:0] wq_data[$];
    int           wq_cyc[$];
    int           acc_q[$];
    int           ready_in_write;
    int           data_leak;

    bank_loader_if #(.IN_W(32), .LANES(4)) bus ();

    bank_loader #(.IN_W(32), .LANES(4)) dut (
        .vsi_clk     (clk),
        .vsi_reset_n (rst_n),
        .bus         (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.vsi_inputChipSelect === 1'b1) begin
                wq_addr.push_back(bus.vsi_inputAddr);
                wq_data.push_back(bus.vsi_inputData);
                wq_cyc.push_back(cyc);
                if (bus.s_ready !== 1'b0) ready_in_write++;
            end else if (bus.vsi_inputData !== '0) begin
                data_leak++;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [127:0] wd(input int i);
        return (i < wq_data.size()) ? wq_data[i] : 'x;
    endfunction

    function automatic logic [127:0] wa(input int i);
        return (i < wq_addr.size()) ? 128'(wq_addr[i]) : 'x;
    endfunction

    task automatic clear_log();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
        acc_q.delete();
        ready_in_write = 0;
    endtask

    task automatic do_start(input logic [6:0] a);
        bus.start      = 1'b1;
        bus.start_addr = a;
        @(posedge clk);
        @(negedge clk);
        bus.start      = 1'b0;
        bus.start_addr = '0;
    endtask

    // Called at a falling edge; returns at the falling edge after the word is taken
    task automatic push(input logic [31:0] d, input logic l, input bit gap);
        int n;
        n = 0;
        if (gap) begin
            bus.s_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        bus.s_data  = d;
        bus.s_valid = 1'b1;
        bus.s_last  = l;
        while (bus.s_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("push_timeout", 128'(n >= 20), 128'(0));
        if (n < 20) begin
            @(posedge clk);
            @(negedge clk);
            acc_q.push_back(cyc);
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_data  = '0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 128'(n < 40), 128'(1));
    endtask

    initial begin
        cyc            = 0;
        passed         = 0;
        total          = 0;
        ready_in_write = 0;
        data_leak      = 0;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.s_data     = '0;
        bus.s_valid    = 1'b0;
        bus.s_last     = 1'b0;

        // Reset asserted before any clock edge: outputs must clear asynchronously
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_s_ready", 128'(bus.s_ready), 128'(0));
        chk("rst_cs", 128'(bus.vsi_inputChipSelect), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_done", 128'(bus.done), 128'(0));
        chk("rst_overflow", 128'(bus.overflow), 128'(0));
        chk("rst_data", bus.vsi_inputData, 128'(0));
        chk("rst_addr", 128'(bus.vsi_inputAddr), 128'(0));
        chk("rst_lines", 128'(bus.lines_written), 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full line at address 5
        clear_log();
        do_start(7'd5);
        chk("t1_busy", 128'(bus.busy), 128'(1));
        chk("t1_ready", 128'(bus.s_ready), 128'(1));
        push(32'h11111111, 1'b0, 1'b0);
        push(32'h22222222, 1'b0, 1'b0);
        push(32'h33333333, 1'b0, 1'b0);
        push(32'h44444444, 1'b1, 1'b0);
        chk("t1_cs", 128'(bus.vsi_inputChipSelect), 128'(1));
        chk("t1_ready_in_write", 128'(bus.s_ready), 128'(0));
        wait_done();
        chk("t1_lines", 128'(bus.lines_written), 128'(1));
        chk("t1_nwrites", 128'(wq_addr.size()), 128'(1));
        chk("t1_addr", wa(0), 128'(5));
        chk("t1_data", wd(0), 128'h44444444_33333333_22222222_11111111);
        chk("t1_latency", 128'(wq_cyc.size() > 0 ? wq_cyc[0] - acc_q[3] : -1), 128'(0));
        chk("t1_burst", 128'(acc_q[3] - acc_q[0]), 128'(3));
        @(negedge clk);
        chk("t1_idle_busy", 128'(bus.busy), 128'(0));
        chk("t1_idle_done", 128'(bus.done), 128'(0));

        // Partial second line, zero padded
        clear_log();
        do_start(7'd0);
        for (int i = 1; i <= 6; i++) push(32'hA0000000 + 32'(i), 1'(i == 6), 1'b0);
        wait_done();
        chk("t2_lines", 128'(bus.lines_written), 128'(2));
        chk("t2_nwrites", 128'(wq_addr.size()), 128'(2));
        chk("t2_addr0", wa(0), 128'(0));
        chk("t2_data0", wd(0), 128'hA0000004_A0000003_A0000002_A0000001);
        chk("t2_addr1", wa(1), 128'(1));
        chk("t2_data1", wd(1), 128'h00000000_00000000_A0000006_A0000005);
        chk("t2_write_gap", 128'(acc_q[4] - acc_q[3]), 128'(2));
        @(negedge clk);

        // Random valid gaps must not change the packed lines
        clear_log();
        do_start(7'h20);
        for (int i = 1; i <= 8; i++) push(32'hB0000000 + 32'(i), 1'(i == 8), 1'($urandom_range(0, 1)));
        wait_done();
        chk("t3_lines", 128'(bus.lines_written), 128'(2));
        chk("t3_nwrites", 128'(wq_addr.size()), 128'(2));
        chk("t3_addr0", wa(0), 128'h20);
        chk("t3_data0", wd(0), 128'hB0000004_B0000003_B0000002_B0000001);
        chk("t3_addr1", wa(1), 128'h21);
        chk("t3_data1", wd(1), 128'hB0000008_B0000007_B0000006_B0000005);
        chk("t3_ready_in_write", 128'(ready_in_write), 128'(0));
        @(negedge clk);

        // Start pulse during FILL is ignored
        clear_log();
        do_start(7'h40);
        push(32'hC0000001, 1'b0, 1'b0);
        push(32'hC0000002, 1'b0, 1'b0);
        do_start(7'd9);
        chk("t5_busy", 128'(bus.busy), 128'(1));
        chk("t5_ready", 128'(bus.s_ready), 128'(1));
        for (int i = 3; i <= 8; i++) push(32'hC0000000 + 32'(i), 1'(i == 8), 1'b0);
        wait_done();
        chk("t5_nwrites", 128'(wq_addr.size()), 128'(2));
        chk("t5_addr0", wa(0), 128'h40);
        chk("t5_data0", wd(0), 128'hC0000004_C0000003_C0000002_C0000001);
        chk("t5_addr1", wa(1), 128'h41);
        chk("t5_data1", wd(1), 128'hC0000008_C0000007_C0000006_C0000005);
        @(negedge clk);

        // Reset in the middle of a line
        clear_log();
        do_start(7'h10);
        push(32'hD0000001, 1'b0, 1'b0);
        push(32'hD0000002, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_cs", 128'(bus.vsi_inputChipSelect), 128'(0));
        chk("t6_busy", 128'(bus.busy), 128'(0));
        chk("t6_ready", 128'(bus.s_ready), 128'(0));
        chk("t6_addr", 128'(bus.vsi_inputAddr), 128'(0));
        chk("t6_data", bus.vsi_inputData, 128'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_no_write", 128'(wq_addr.size()), 128'(0));
        do_start(7'h11);
        push(32'hE0000001, 1'b1, 1'b0);
        wait_done();
        chk("t6_nwrites", 128'(wq_addr.size()), 128'(1));
        chk("t6_addr_after", wa(0), 128'h11);
        chk("t6_data_after", wd(0), 128'h00000000_00000000_00000000_E0000001);
        chk("t6_lines", 128'(bus.lines_written), 128'(1));
        @(negedge clk);

        // Address limit at 127
        clear_log();
        do_start(7'd126);
`ifdef BANK_LOADER_WRAP_EN
        for (int i = 1; i <= 12; i++) push(32'hF0000000 + 32'(i), 1'(i == 12), 1'b0);
        wait_done();
        chk("t4_nwrites", 128'(wq_addr.size()), 128'(3));
        chk("t4_addr0", wa(0), 128'(126));
        chk("t4_addr1", wa(1), 128'(127));
        chk("t4_addr2", wa(2), 128'(0));
        chk("t4_data2", wd(2), 128'hF000000C_F000000B_F000000A_F0000009);
        chk("t4_overflow", 128'(bus.overflow), 128'(0));
        chk("t4_lines", 128'(bus.lines_written), 128'(3));
        @(negedge clk);
`else
        for (int i = 1; i <= 8; i++) push(32'hF0000000 + 32'(i), 1'b0, 1'b0);
        @(negedge clk);
        chk("t4_overflow", 128'(bus.overflow), 128'(1));
        chk("t4_ready", 128'(bus.s_ready), 128'(0));
        chk("t4_busy", 128'(bus.busy), 128'(1));
        bus.s_data  = 32'hF0000009;
        bus.s_valid = 1'b1;
        repeat (4) @(negedge clk);
        bus.s_valid = 1'b0;
        chk("t4_nwrites", 128'(wq_addr.size()), 128'(2));
        chk("t4_addr0", wa(0), 128'(126));
        chk("t4_addr1", wa(1), 128'(127));
        chk("t4_data1", wd(1), 128'hF0000008_F0000007_F0000006_F0000005);
        chk("t4_lines", 128'(bus.lines_written), 128'(2));
        clear_log();
        do_start(7'd3);
        chk("t4_ovf_cleared", 128'(bus.overflow), 128'(0));
        push(32'h90000001, 1'b1, 1'b0);
        wait_done();
        chk("t4_restart_addr", wa(0), 128'(3));
        chk("t4_restart_data", wd(0), 128'h00000000_00000000_00000000_90000001);
        @(negedge clk);
`endif
        chk("data_zero_outside_write", 128'(data_leak), 128'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bank_loader.md
BANK_LOADER -- requirements
Module: bank_loader

Interface
REQ-001 SHALL have parameter IN_W, default 32, meaning input word width; fixed so that 4*IN_W = 128.
REQ-002 SHALL have parameter LANES, default 4, meaning input words packed per bank line.
REQ-003 SHALL have port vsi_clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port vsi_reset_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a load.
REQ-006 SHALL have port start_addr  input  7  first bank line address, sampled on start.
REQ-007 SHALL have port s_data  input  32  stream word.
REQ-008 SHALL have port s_valid  input  1  s_data is valid.
REQ-009 SHALL have port s_last  input  1  marks the final word of the load.
REQ-010 SHALL have port s_ready  output  1  loader accepts the word this cycle.
REQ-011 SHALL have port vsi_inputData  output  128  packed line to the bank.
REQ-012 SHALL have port vsi_inputAddr  output  7  bank write address.
REQ-013 SHALL have port vsi_inputChipSelect  output  1  bank write strobe, one cycle per line.
REQ-014 SHALL have port busy  output  1  load in progress.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port lines_written  output  8  lines written in the current or last load, saturating at 255.
REQ-017 SHALL have port overflow  output  1  address space exhausted.

Function
REQ-018 SHALL implement states IDLE, FILL, WRITE, DONE and HALT.
REQ-019 SHALL go from IDLE to FILL on start; in the same edge it latches start_addr, clears lane index, lines_written and the line buffer.
REQ-020 SHALL ignore start in FILL, WRITE and DONE.
REQ-021 SHALL drive s_ready=1 only in FILL; a word transfers when s_valid and s_ready are both 1.
REQ-022 SHALL place the k-th accepted word of a line in bits [32k+31:32k], with k=0..3.
REQ-023 SHALL enter WRITE on the edge that accepts lane 3 or a word with s_last=1; unfilled lanes stay zero.
REQ-024 SHALL hold vsi_inputChipSelect=1 for exactly the one WRITE cycle, with vsi_inputData and vsi_inputAddr registered and stable in that cycle.
REQ-025 SHALL hold vsi_inputChipSelect=0 and vsi_inputData=0 outside WRITE.
REQ-026 SHALL leave WRITE on the next edge: increment the address, increment lines_written, clear the lane index and buffer; go to DONE if the line held s_last, else to FILL.
REQ-027 SHALL pulse done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-028 SHALL give a latency of 1 cycle from the edge accepting the last word of a line to the chip-select cycle, and sustain 4 words per 5 cycles.
REQ-029 SHALL assert busy in FILL, WRITE, DONE and HALT.
REQ-030 SHALL write a zero-padded line for an s_last on lane 0..2; s_last on lane 3 SHALL NOT add an extra line.

Reset
REQ-031 SHALL set on reset assertion, independent of vsi_clk: state IDLE; s_ready, vsi_inputChipSelect, busy, done and overflow to 0; vsi_inputData, vsi_inputAddr and lines_written to 0.
REQ-032 SHALL abandon any partly packed line when reset is asserted mid-load, with no bank write; after release the block SHALL accept a new start.

Configuration
REQ-033 SHALL compile the address-wrap feature in with macro BANK_LOADER_WRAP_EN.
REQ-034 SHALL, when BANK_LOADER_WRAP_EN is defined, wrap the address from 127 to 0 and continue loading; overflow stays 0.
REQ-035 SHALL, when BANK_LOADER_WRAP_EN is undefined, behave as follows after a non-final line is written at address 127: go to HALT, set overflow=1, s_ready=0, busy=1, no further writes.
REQ-036 SHALL, in HALT, clear overflow on start and restart as from IDLE.
REQ-037 SHALL, when the line written at address 127 holds s_last, go to DONE normally.

Verification
REQ-038 SHALL check a full line: start, start_addr=5, words 0x11111111, 0x22222222, 0x33333333, 0x44444444 with s_last on the 4th -> one write, addr 5, data 0x44444444_33333333_22222222_11111111, then done, lines_written=1.
REQ-039 SHALL check a partial line: start_addr=0, 6 words with s_last on word 6 -> writes at addr 0 and addr 1; addr 1 data upper 64 bits zero; lines_written=2.
REQ-040 SHALL check backpressure: s_valid toggled randomly over 8 words -> the same two lines as with continuous s_valid; s_ready=0 in every WRITE cycle.
REQ-041 SHALL check the address limit: start_addr=126 with 12 words -> wrap build writes addr 126, 127, 0; non-wrap build writes 126 and 127, then overflow=1, s_ready=0.
REQ-042 SHALL check reset mid-line: reset asserted after 2 of 4 words -> chip select never asserts; outputs are 0 immediately on reset.
REQ-043 SHALL check start while busy: start pulse in FILL with start_addr=9 -> ignored; the address sequence is unchanged.
